// File: rtl/stereo_pkg.sv
// Shared frame constants and scheduler state encoding for the stereo pipeline.
package stereo_pkg;

  localparam int unsigned FRAME_W       = 320;
  localparam int unsigned FRAME_H       = 240;
  localparam int unsigned RESULT_ADDR_W = $clog2(FRAME_W * FRAME_H);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    PROCESS
  } sched_state_t;

endpackage

// File: rtl/stereo_frame_scheduler_if.sv
// Camera, engine, display and result-BRAM signals seen by the frame scheduler.
interface stereo_frame_scheduler_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 8
);

  logic              cam_load_req;
  logic              cam_load_done;
  logic              cam_load_grant;
  logic              eng_start;
  logic              eng_done;
  logic              eng_wr_valid;
  logic [ADDR_W-1:0] eng_wr_addr;
  logic [DATA_W-1:0] eng_wr_data;
  logic              disp_rd_req;
  logic [ADDR_W-1:0] disp_rd_addr;
  logic              disp_rd_ack;
  logic              disp_rd_valid;
  logic [DATA_W-1:0] disp_rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    input  cam_load_req, cam_load_done, eng_done, eng_wr_valid, eng_wr_addr, eng_wr_data,
           disp_rd_req, disp_rd_addr, ram_dout,
    output cam_load_grant, eng_start, disp_rd_ack, disp_rd_valid, disp_rd_data,
           ram_addr, ram_we, ram_din
  );

  modport slave (
    output cam_load_req, cam_load_done, eng_done, eng_wr_valid, eng_wr_addr, eng_wr_data,
           disp_rd_req, disp_rd_addr, ram_dout,
    input  cam_load_grant, eng_start, disp_rd_ack, disp_rd_valid, disp_rd_data,
           ram_addr, ram_we, ram_din
  );

endinterface

// File: rtl/result_port_arb.sv
// Single-port result BRAM arbiter: engine writes always win, display reads fill idle slots,
// and a READ_LAT-deep valid pipeline returns registered read data.
module result_port_arb #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic              rd_slot;
  // Stage 0 lines up with the address on the BRAM port; stage READ_LAT with valid ram_dout.
  logic [READ_LAT:0] rd_pipe_q;

  assign rd_slot = rd_req & ~wr_valid;
  assign rd_ack  = rd_pipe_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_din   <= '0;
      rd_pipe_q <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      ram_we    <= wr_valid;
      rd_pipe_q <= {rd_pipe_q[READ_LAT-1:0], rd_slot};
      rd_valid  <= rd_pipe_q[READ_LAT];
      if (wr_valid) begin
        ram_addr <= wr_addr;
        ram_din  <= wr_data;
      end else if (rd_req) begin
        ram_addr <= rd_addr;
      end
      if (rd_pipe_q[READ_LAT]) begin
        rd_data <= ram_dout;
      end
    end
  end

endmodule

// File: rtl/stereo_frame_scheduler.sv
// Per-frame sequencer (camera load, one engine pass, idle) plus result BRAM port arbitration.
module stereo_frame_scheduler
  import stereo_pkg::*;
#(
  parameter int unsigned ADDR_W   = RESULT_ADDR_W,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 2
) (
  input  logic                      clk_100mhz,
  input  logic                      sys_rst,
  stereo_frame_scheduler_if.master  bus,
  output logic                      busy,
  output logic [15:0]               frame_count,
  output logic                      protocol_err
);

  sched_state_t state_q, state_d;
  logic         eng_start_q;
  logic [15:0]  frame_count_q;
  logic         protocol_err_q;
  logic         err_now;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cam_load_req)  state_d = LOAD;
      LOAD:    if (bus.cam_load_done) state_d = START;
      START:                          state_d = PROCESS;
      PROCESS: if (bus.eng_done)      state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Stray handshakes are ignored by the FSM, but stray writes still reach the BRAM.
  assign err_now = (bus.cam_load_done && (state_q != LOAD))
                 || (bus.eng_done && (state_q != PROCESS))
                 || (bus.eng_wr_valid && (state_q != PROCESS));

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      eng_start_q    <= 1'b0;
      frame_count_q  <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      eng_start_q    <= (state_q == START);
      protocol_err_q <= protocol_err_q | err_now;
      if ((state_q == PROCESS) && bus.eng_done) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign bus.cam_load_grant = (state_q == LOAD);
  assign bus.eng_start      = eng_start_q;
  assign busy               = (state_q != IDLE);
  assign frame_count        = frame_count_q;
  assign protocol_err       = protocol_err_q;

  result_port_arb #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_arb (
    .clk      (clk_100mhz),
    .rst      (sys_rst),
    .wr_valid (bus.eng_wr_valid),
    .wr_addr  (bus.eng_wr_addr),
    .wr_data  (bus.eng_wr_data),
    .rd_req   (bus.disp_rd_req),
    .rd_addr  (bus.disp_rd_addr),
    .rd_ack   (bus.disp_rd_ack),
    .rd_valid (bus.disp_rd_valid),
    .rd_data  (bus.disp_rd_data),
    .ram_addr (bus.ram_addr),
    .ram_we   (bus.ram_we),
    .ram_din  (bus.ram_din),
    .ram_dout (bus.ram_dout)
  );

endmodule

// File: tb/tb_stereo_frame_scheduler.sv
// Directed bench for stereo_frame_scheduler with a 2-cycle-latency result BRAM model.
module tb_stereo_frame_scheduler;

  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned READ_LAT = 2;

  logic        clk_100mhz;
  logic        sys_rst;
  logic        busy;
  logic [15:0] frame_count;
  logic        protocol_err;

  int n_cmp  = 0;
  int n_fail = 0;

  stereo_frame_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  stereo_frame_scheduler #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .sys_rst      (sys_rst),
    .bus          (bus),
    .busy         (busy),
    .frame_count  (frame_count),
    .protocol_err (protocol_err)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  // Result BRAM: address registered, then output registered (2-cycle read latency).
  logic [DATA_W-1:0] mem [0:1023];
  logic [DATA_W-1:0] mem_p1;
  always @(posedge clk_100mhz) begin
    mem_p1       <= mem[bus.ram_addr[9:0]];
    bus.ram_dout <= mem_p1;
    if (bus.ram_we) mem[bus.ram_addr[9:0]] <= bus.ram_din;
  end

  function automatic logic [7:0] init_val(input int a);
    logic [7:0] v;
    v = a[7:0];
    return v ^ 8'h5A;
  endfunction

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_cmp++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expd);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
    sys_rst           = 1'b1;
    bus.cam_load_req  = 1'b0;
    bus.cam_load_done = 1'b0;
    bus.eng_done      = 1'b0;
    bus.eng_wr_valid  = 1'b0;
    bus.eng_wr_addr   = '0;
    bus.eng_wr_data   = '0;
    bus.disp_rd_req   = 1'b0;
    bus.disp_rd_addr  = '0;

    // Reset state
    tick();
    tick();
    check("rst_grant", 32'(bus.cam_load_grant), 0);
    check("rst_eng_start", 32'(bus.eng_start), 0);
    check("rst_ack", 32'(bus.disp_rd_ack), 0);
    check("rst_valid", 32'(bus.disp_rd_valid), 0);
    check("rst_data", 32'(bus.disp_rd_data), 0);
    check("rst_ram_addr", 32'(bus.ram_addr), 0);
    check("rst_ram_we", 32'(bus.ram_we), 0);
    check("rst_ram_din", 32'(bus.ram_din), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_protocol_err", 32'(protocol_err), 0);
    sys_rst = 1'b0;
    tick();

    // Full frame: request at T, done at T+100, start pulse at T+102
    bus.cam_load_req = 1'b1;
    tick();
    check("frame_grant_t1", 32'(bus.cam_load_grant), 1);
    check("frame_busy_t1", 32'(busy), 1);
    repeat (49) tick();
    bus.cam_load_req = 1'b0;
    repeat (50) tick();
    check("frame_grant_held_t100", 32'(bus.cam_load_grant), 1);
    bus.cam_load_done = 1'b1;
    tick();
    bus.cam_load_done = 1'b0;
    check("frame_grant_drop_t101", 32'(bus.cam_load_grant), 0);
    check("frame_start_t101", 32'(bus.eng_start), 0);
    tick();
    check("frame_start_t102", 32'(bus.eng_start), 1);
    tick();
    check("frame_start_t103", 32'(bus.eng_start), 0);
    check("frame_busy_t103", 32'(busy), 1);

    // Collision during PROCESS: write 0x123 and read 0x50 requested together
    bus.eng_wr_valid = 1'b1;
    bus.eng_wr_addr  = 17'h00123;
    bus.eng_wr_data  = 8'h2A;
    bus.disp_rd_req  = 1'b1;
    bus.disp_rd_addr = 17'h00050;
    tick();
    bus.eng_wr_valid = 1'b0;
    check("coll_we", 32'(bus.ram_we), 1);
    check("coll_wr_addr", 32'(bus.ram_addr), 32'h123);
    check("coll_wr_din", 32'(bus.ram_din), 32'h2A);
    check("coll_no_ack", 32'(bus.disp_rd_ack), 0);
    tick();
    bus.disp_rd_req = 1'b0;
    check("coll_rd_we", 32'(bus.ram_we), 0);
    check("coll_rd_addr", 32'(bus.ram_addr), 32'h50);
    check("coll_ack", 32'(bus.disp_rd_ack), 1);
    tick();
    check("coll_ack_drop", 32'(bus.disp_rd_ack), 0);
    check("coll_idle_addr_hold", 32'(bus.ram_addr), 32'h50);
    tick();
    check("coll_valid_early", 32'(bus.disp_rd_valid), 0);
    tick();
    check("coll_valid", 32'(bus.disp_rd_valid), 1);
    check("coll_data", 32'(bus.disp_rd_data), 32'(init_val(32'h50)));
    tick();
    check("coll_valid_drop", 32'(bus.disp_rd_valid), 0);
    check("coll_no_err", 32'(protocol_err), 0);

    // Load request during PROCESS is held off until after eng_done
    bus.cam_load_req = 1'b1;
    tick();
    tick();
    check("hold_grant_process", 32'(bus.cam_load_grant), 0);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    check("done_busy", 32'(busy), 0);
    check("done_frame_count", 32'(frame_count), 1);
    check("done_grant_d1", 32'(bus.cam_load_grant), 0);
    tick();
    check("done_grant_d2", 32'(bus.cam_load_grant), 1);
    check("done_no_err", 32'(protocol_err), 0);

    // Async reset mid-LOAD with two reads in flight
    bus.disp_rd_req  = 1'b1;
    bus.disp_rd_addr = 17'h00123;
    tick();
    bus.disp_rd_addr = 17'h00005;
    tick();
    bus.disp_rd_req = 1'b0;
    check("inflight_ack", 32'(bus.disp_rd_ack), 1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("async_grant", 32'(bus.cam_load_grant), 0);
    check("async_busy", 32'(busy), 0);
    check("async_ack", 32'(bus.disp_rd_ack), 0);
    check("async_frame_count", 32'(frame_count), 0);
    tick();
    sys_rst = 1'b0;
    bus.cam_load_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("flush_no_valid", 32'(bus.disp_rd_valid), 0);
    end

    // Readback of the engine write, then back-to-back reads 0..9
    bus.disp_rd_req  = 1'b1;
    bus.disp_rd_addr = 17'h00123;
    tick();
    bus.disp_rd_req = 1'b0;
    repeat (3) tick();
    check("wb_valid", 32'(bus.disp_rd_valid), 1);
    check("wb_data", 32'(bus.disp_rd_data), 32'h2A);
    tick();

    for (int j = 0; j < 15; j++) begin
      if (j < 10) begin
        bus.disp_rd_req  = 1'b1;
        bus.disp_rd_addr = 17'(j);
      end else begin
        bus.disp_rd_req = 1'b0;
      end
      tick();
      check("b2b_ack", 32'(bus.disp_rd_ack), 32'((j + 1) <= 10));
      check("b2b_valid", 32'(bus.disp_rd_valid), 32'(((j + 1) >= 4) && ((j + 1) <= 13)));
      if (((j + 1) >= 4) && ((j + 1) <= 13)) begin
        check("b2b_data", 32'(bus.disp_rd_data), 32'(init_val(j + 1 - 4)));
      end
    end

    // Protocol error: eng_done in IDLE
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    check("perr_set", 32'(protocol_err), 1);
    check("perr_idle", 32'(busy), 0);
    check("perr_count", 32'(frame_count), 0);
    tick();
    check("perr_sticky", 32'(protocol_err), 1);
    sys_rst = 1'b1;
    #1;
    check("perr_cleared", 32'(protocol_err), 0);
    tick();
    sys_rst = 1'b0;
    tick();

    // Stray write while IDLE is performed and flagged
    bus.eng_wr_valid = 1'b1;
    bus.eng_wr_addr  = 17'h00007;
    bus.eng_wr_data  = 8'hC3;
    tick();
    bus.eng_wr_valid = 1'b0;
    check("stray_we", 32'(bus.ram_we), 1);
    check("stray_addr", 32'(bus.ram_addr), 32'h7);
    check("stray_err", 32'(protocol_err), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
